// File: rtl/fetch_decode_queue_if.sv
// rtl/fetch_decode_queue_if.sv - fetch/decode queue handshake bundle
interface fetch_decode_queue_if #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic               flush;
    logic               in_valid;
    logic               in_ready;
    logic [ADDR_W-1:0]  imemaddr;
    logic [INSTR_W-1:0] imemload;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  imemaddr_ID;
    logic [INSTR_W-1:0] instr_ID;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;

    // Queue side
    modport slave (
        input  flush, in_valid, imemaddr, imemload, out_ready,
        output in_ready, out_valid, imemaddr_ID, instr_ID, count, full, empty
    );

    // Fetch/decode side
    modport master (
        output flush, in_valid, imemaddr, imemload, out_ready,
        input  in_ready, out_valid, imemaddr_ID, instr_ID, count, full, empty
    );
endinterface

// File: rtl/fetch_decode_queue.sv
// rtl/fetch_decode_queue.sv - circular FWFT instruction queue between fetch and decode
module fetch_decode_queue #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32,
    parameter int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    fetch_decode_queue_if.slave   q
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [ADDR_W-1:0]  addr_mem  [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   cnt;

    logic full_w;
    logic empty_w;
    logic push;
    logic pop;

    // Status flags come straight from the occupancy register so in_ready/out_valid never
    // depend combinationally on the handshake inputs.
    assign full_w  = (cnt == CNT_W'(DEPTH));
    assign empty_w = (cnt == '0);
    assign push    = q.in_valid & ~full_w;
    assign pop     = q.out_ready & ~empty_w;

    assign q.full        = full_w;
    assign q.empty       = empty_w;
    assign q.in_ready    = ~full_w;
    assign q.out_valid   = ~empty_w;
    assign q.count       = cnt;
    assign q.imemaddr_ID = empty_w ? '0 : addr_mem[rd_ptr];
    assign q.instr_ID    = empty_w ? '0 : instr_mem[rd_ptr];

    // Entry storage; contents are don't-care after reset/flush since the pointers restart.
    always_ff @(posedge CLK) begin
        if (!RST && !q.flush && push) begin
            addr_mem[wr_ptr]  <= q.imemaddr;
            instr_mem[wr_ptr] <= q.imemload;
        end
    end

    // Pointers and occupancy: reset beats flush beats push/pop; pointers wrap at DEPTH.
    always_ff @(posedge CLK) begin
        if (RST || q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + CNT_W'(1);
            end else if (pop && !push) begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_fetch_decode_queue.sv
// tb/tb_fetch_decode_queue.sv - scoreboard bench for fetch_decode_queue
module tb_fetch_decode_queue;
    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    fetch_decode_queue_if #(.DEPTH(4), .ADDR_W(32), .INSTR_W(32)) fq ();
    fetch_decode_queue_if #(.DEPTH(2), .ADDR_W(16), .INSTR_W(32)) f2 ();
    fetch_decode_queue_if #(.DEPTH(8), .ADDR_W(16), .INSTR_W(32)) f8 ();

    fetch_decode_queue #(.DEPTH(4), .ADDR_W(32), .INSTR_W(32)) dut (
        .CLK(CLK), .RST(RST), .q(fq.slave)
    );
    fetch_decode_queue #(.DEPTH(2), .ADDR_W(16), .INSTR_W(32)) dut2 (
        .CLK(CLK), .RST(RST), .q(f2.slave)
    );
    fetch_decode_queue #(.DEPTH(8), .ADDR_W(16), .INSTR_W(32)) dut8 (
        .CLK(CLK), .RST(RST), .q(f8.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [63:0] sb [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        head = (sb.size() > 0) ? sb[0] : 64'd0;
        check("count",     64'(fq.count),     64'(sb.size()));
        check("empty",     64'(fq.empty),     64'(sb.size() == 0));
        check("full",      64'(fq.full),      64'(sb.size() == DEPTH));
        check("in_ready",  64'(fq.in_ready),  64'(sb.size() != DEPTH));
        check("out_valid", 64'(fq.out_valid), 64'(sb.size() != 0));
        check("head",      {fq.imemaddr_ID, fq.instr_ID}, head);
        check("count_le_depth", 64'(fq.count <= DEPTH), 64'd1);
    endtask

    task automatic cycle(input logic f, input logic iv, input logic [31:0] a,
                         input logic [31:0] d, input logic ordy);
        bit can_push;
        bit can_pop;
        check_outputs();
        fq.flush     = f;
        fq.in_valid  = iv;
        fq.imemaddr  = a;
        fq.imemload  = d;
        fq.out_ready = ordy;
        can_push = (sb.size() != DEPTH);
        can_pop  = (sb.size() != 0);
        if (f) begin
            sb.delete();
        end else begin
            if (ordy && can_pop) void'(sb.pop_front());
            if (iv && can_push) sb.push_back({a, d});
        end
        @(posedge CLK);
        #1;
    endtask

    initial begin
        logic [47:0] exp48;
        fq.flush = 0; fq.in_valid = 1; fq.imemaddr = 32'hDEAD; fq.imemload = 32'hBEEF; fq.out_ready = 0;
        f2.flush = 0; f2.in_valid = 0; f2.imemaddr = '0; f2.imemload = '0; f2.out_ready = 0;
        f8.flush = 0; f8.in_valid = 0; f8.imemaddr = '0; f8.imemload = '0; f8.out_ready = 0;

        // Reset held two cycles with fetch presenting an entry
        RST = 1;
        repeat (2) @(posedge CLK);
        #1;
        check_outputs();
        RST = 0;
        fq.in_valid = 0;
        cycle(0, 0, 0, 0, 0);

        // Fill to full, rejected fifth entry, then drain in order
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'(4 * i), 32'hA0 + 32'(i), 0);
        cycle(0, 1, 32'h10, 32'hA4, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // Simultaneous push/pop at count=1, pointers wrap
        cycle(0, 1, 32'h100, 32'hC0, 0);
        for (int i = 1; i <= 10; i++) cycle(0, 1, 32'h100 + 32'(4 * i), 32'hC0 + 32'(i), 1);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // Flush with a concurrent push and pop drops everything
        for (int i = 0; i < 3; i++) cycle(0, 1, 32'h20 + 32'(4 * i), 32'hD0 + 32'(i), 0);
        cycle(1, 1, 32'h40, 32'hEE, 1);
        cycle(0, 1, 32'h80, 32'hE8, 0);
        cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // Full with pop: pop only, push accepted the following cycle
        for (int i = 0; i < 4; i++) cycle(0, 1, 32'h60 + 32'(4 * i), 32'hF0 + 32'(i), 0);
        cycle(0, 1, 32'h90, 32'hF8, 1);
        cycle(0, 1, 32'h90, 32'hF8, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1);
        cycle(0, 0, 0, 0, 0);

        // Random traffic with occasional flush
        for (int i = 0; i < 200; i++) begin
            cycle(($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)), $urandom, $urandom,
                  1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1);

        // Mid-stream reset overrides in_valid/out_ready
        cycle(0, 1, 32'h300, 32'h11, 0);
        cycle(0, 1, 32'h304, 32'h12, 0);
        check_outputs();
        fq.in_valid = 1; fq.imemaddr = 32'h308; fq.imemload = 32'h13; fq.out_ready = 1;
        RST = 1;
        sb.delete();
        @(posedge CLK);
        #1;
        RST = 0;
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);

        // DEPTH=2 and DEPTH=8 fill, over-fill attempt, and drain
        for (int i = 0; i < 9; i++) begin
            check("d2_full",  64'(f2.full),  64'(i >= 2));
            check("d2_count", 64'(f2.count), 64'(i < 2 ? i : 2));
            check("d8_full",  64'(f8.full),  64'(i >= 8));
            check("d8_count", 64'(f8.count), 64'(i < 8 ? i : 8));
            f2.in_valid = 1; f2.imemaddr = 16'(16'h200 + 4 * i); f2.imemload = 32'hB0 + 32'(i);
            f8.in_valid = 1; f8.imemaddr = 16'(16'h200 + 4 * i); f8.imemload = 32'hB0 + 32'(i);
            @(posedge CLK);
            #1;
        end
        f2.in_valid = 0; f8.in_valid = 0;
        for (int j = 0; j < 9; j++) begin
            exp48 = (j < 2) ? {16'(16'h200 + 4 * j), 32'hB0 + 32'(j)} : 48'd0;
            check("d2_head", 64'({f2.imemaddr_ID, f2.instr_ID}), 64'(exp48));
            exp48 = (j < 8) ? {16'(16'h200 + 4 * j), 32'hB0 + 32'(j)} : 48'd0;
            check("d8_head", 64'({f8.imemaddr_ID, f8.instr_ID}), 64'(exp48));
            f2.out_ready = 1; f8.out_ready = 1;
            @(posedge CLK);
            #1;
        end
        check("d2_empty", 64'(f2.empty), 64'd1);
        check("d8_empty", 64'(f8.empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

Parametrised instruction queue between fetch and decode, the successor to the single-entry IF/ID latch. It buffers up to DEPTH fetched (PC, instruction) pairs so fetch can run ahead while decode stalls. It uses valid/ready handshakes on both sides and a single-cycle flush for branch/jump redirects. Empty-queue outputs are all-zero bubbles, matching the NOP encoding decode already expects.

## Interface

Parameters:
- DEPTH, 4: entry count; power of two, ≥ 2.
- ADDR_W, 32: PC width.
- INSTR_W, 32: instruction width.
- CNT_W, $clog2(DEPTH+1): occupancy counter width (derived; do not override).

Ports:
- CLK  in  1  clock, all state updates on rising edge.
- RST  in  1  reset; one clock, synchronous, active-high.
- flush  in  1  discard all entries (redirect from EX/MEM).
- in_valid  in  1  fetch presents an entry.
- in_ready  out  1  queue can accept; equals !full.
- imemaddr  in  ADDR_W  PC of fetched instruction.
- imemload  in  INSTR_W  fetched instruction word.
- out_valid  out  1  head entry valid; equals !empty.
- out_ready  in  1  decode consumes head this cycle.
- imemaddr_ID  out  ADDR_W  PC of head entry, '0 when empty.
- instr_ID  out  INSTR_W  head instruction, '0 when empty.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

## Operation

- Storage is a circular buffer of DEPTH entries with wr_ptr and rd_ptr, each $clog2(DEPTH) bits and wrapping modulo DEPTH. Occupancy is held in count.
- push = in_valid & in_ready. pop = out_valid & out_ready.
- Update priority each edge: RST > flush > push/pop.
  - RST: wr_ptr, rd_ptr and count go to 0. Storage contents are don't-care.
  - flush: same as RST for the pointers and count. A push or pop in the same cycle is ignored, and the entry fetch presented that cycle is dropped.
  - push only: write the entry at wr_ptr, wr_ptr+1, count+1.
  - pop only: rd_ptr+1, count−1.
  - push & pop: write at wr_ptr, both pointers advance, count unchanged. This is only possible when not full, because in_ready = !full.
- Outputs are first-word-fall-through. imemaddr_ID and instr_ID come from the entry at rd_ptr, gated to '0 when empty.
- in_ready, out_valid, full, empty and count depend only on registered state. There is no combinational path from in_valid or out_ready to any output.
- Push when full cannot occur (in_ready=0). Fetch must hold its entry until in_ready.
- Pop when empty cannot occur (out_valid=0). out_ready while empty is ignored.
- Overflow and underflow of count are impossible by construction. The bench asserts count ≤ DEPTH.

## Timing

- Reset values: count=0, empty=1, full=0, in_ready=1, out_valid=0, imemaddr_ID='0, instr_ID='0.
- Push latency: an entry pushed at edge k into an empty queue appears on imemaddr_ID/instr_ID with out_valid=1 in the cycle after edge k (1-cycle latency, same as the old latch).
- Pop: after the popping edge the next entry (or '0 bubble) is presented combinationally from the new rd_ptr.
- Flush: after the flush edge, out_valid=0, outputs '0 and in_ready=1. A push is accepted at the very next edge.
- Throughput: one push and one pop per cycle sustained while 0 < count < DEPTH.
- When full, a simultaneous pop frees a slot, but in_ready rises only in the following cycle. This one-cycle bubble is intended, to keep in_ready registered.
- RST asserted mid-stream takes effect at the next edge regardless of flush, in_valid or out_ready.

## Test plan

- Reset: hold RST 2 cycles with in_valid=1 → count=0, empty=1, in_ready=1, instr_ID=0, imemaddr_ID=0. No entry is captured.
- Fill/drain, DEPTH=4, out_ready=0: push PCs 0x00,0x04,0x08,0x0C with instrs 0xA0..0xA3 → full=1, in_ready=0 after the 4th edge, and a 5th in_valid is not accepted. Then out_ready=1 for 4 cycles → instr_ID reads 0xA0,0xA1,0xA2,0xA3 in order, then empty=1 and outputs 0.
- Wrap-around: push/pop simultaneously for 10 cycles starting at count=1 → count stays 1, pointers wrap twice, and the PC sequence out matches the sequence in, delayed by one entry.
- Flush: with count=3, assert flush together with in_valid=1 (PC 0x40) and out_ready=1 → next cycle count=0, out_valid=0, instr_ID=0. 0x40 is never output, and the next push (PC 0x80) appears one cycle later.
- Full with pop: at count=4, in_valid=1 and out_ready=1 → pop occurs, no push, count=3. in_ready=1 the next cycle, and the push is accepted then.
- Parameter sweep: repeat the fill/drain test with DEPTH=2 and DEPTH=8, ADDR_W=16 → full asserts at exactly DEPTH entries and data order is preserved.
